// File: rtl/ir_tick_gen_if.sv
// ir_tick_gen_if: control and strobe bundle for the IR timebase.
// The master side (controller/testbench) drives enable, restart and the
// runtime divisor; the slave side (ir_tick_gen) returns the registered strobes.
interface ir_tick_gen_if #(
    parameter int unsigned DIV_W = 11
);
    logic             In_Enable;
    logic             In_Restart;
    logic [DIV_W-1:0] In_Tick_Div;
    logic             Out_Tick;
    logic             Out_Carrier;
    logic             Out_Symbol;
    logic             Out_Symbol_Edge;

    modport master (
        output In_Enable, In_Restart, In_Tick_Div,
        input  Out_Tick, Out_Carrier, Out_Symbol, Out_Symbol_Edge
    );

    modport slave (
        input  In_Enable, In_Restart, In_Tick_Div,
        output Out_Tick, Out_Carrier, Out_Symbol, Out_Symbol_Edge
    );
endinterface

// File: rtl/ir_tick_gen.sv
// ir_tick_gen: timebase for the IR transmit/receive path.
// Divides In_Clock into a one-cycle tick strobe, a 50 % duty carrier and a
// symbol-rate toggle with a matching edge strobe. All outputs are registered
// and meant to be used as clock enables downstream.
// Optional feature: define IR_TICK_GEN_RUNTIME_DIV_EN to load the tick divisor
// from In_Tick_Div on every restart; otherwise the divisor is TICK_DIV.
module ir_tick_gen #(
    parameter int unsigned TICK_DIV          = 174,
    parameter int unsigned DIV_W             = 11,
    parameter int unsigned TICKS_PER_CARRIER = 8,
    parameter int unsigned TICKS_PER_SYMBOL  = 64
) (
    input  logic            In_Clock,
    input  logic            In_Reset,
    ir_tick_gen_if.slave    bus
);

    localparam int unsigned CAR_HALF = TICKS_PER_CARRIER / 2;
    localparam int unsigned CAR_W    = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;
    localparam int unsigned SYM_W    = (TICKS_PER_SYMBOL > 1) ? $clog2(TICKS_PER_SYMBOL) : 1;

    localparam logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN     = DIV_W'(2);
    localparam logic [CAR_W-1:0] CAR_LAST    = CAR_W'(CAR_HALF - 1);
    localparam logic [SYM_W-1:0] SYM_LAST    = SYM_W'(TICKS_PER_SYMBOL - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [CAR_W-1:0] r_car_cnt;
    logic [SYM_W-1:0] r_sym_cnt;
    logic             r_tick;
    logic             r_carrier;
    logic             r_symbol;
    logic             r_symbol_edge;

    logic [DIV_W-1:0] w_div;
    logic             w_div_last;
    logic             w_car_wrap;
    logic             w_sym_wrap;

`ifdef IR_TICK_GEN_RUNTIME_DIV_EN
    logic [DIV_W-1:0] r_div_reg;

    // Active divisor: captured on restart, with 0 and 1 clamped to 2 so a tick never needs zero cycles.
    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            r_div_reg <= DIV_DEFAULT;
        end else if (bus.In_Restart) begin
            r_div_reg <= (bus.In_Tick_Div < DIV_MIN) ? DIV_MIN : bus.In_Tick_Div;
        end
    end

    assign w_div = r_div_reg;
`else
    // Fixed divisor; the runtime divisor input is deliberately ignored.
    logic w_unused_div;
    assign w_unused_div = ^bus.In_Tick_Div;
    assign w_div        = DIV_DEFAULT;
`endif

    assign w_div_last = (r_div_cnt == (w_div - DIV_W'(1)));
    assign w_car_wrap = (r_car_cnt == CAR_LAST);
    assign w_sym_wrap = (r_sym_cnt == SYM_LAST);

    // Divider, carrier and symbol counters plus their registered outputs, in priority reset > restart > enable > hold.
    always_ff @(posedge In_Clock or posedge In_Reset) begin
        // NOTE: state is updated with non-blocking assignments so every counter
        // sees the pre-edge values of the others, matching the flop behaviour.
        if (In_Reset) begin
            r_div_cnt     <= '0;
            r_car_cnt     <= '0;
            r_sym_cnt     <= '0;
            r_tick        <= 1'b0;
            r_carrier     <= 1'b0;
            r_symbol      <= 1'b0;
            r_symbol_edge <= 1'b0;
        end else if (bus.In_Restart) begin
            r_div_cnt     <= '0;
            r_car_cnt     <= '0;
            r_sym_cnt     <= '0;
            r_tick        <= 1'b0;
            r_carrier     <= 1'b0;
            r_symbol      <= 1'b0;
            r_symbol_edge <= 1'b0;
        end else if (bus.In_Enable) begin
            if (w_div_last) begin
                r_div_cnt     <= '0;
                r_tick        <= 1'b1;
                r_car_cnt     <= w_car_wrap ? '0 : r_car_cnt + CAR_W'(1);
                r_sym_cnt     <= w_sym_wrap ? '0 : r_sym_cnt + SYM_W'(1);
                r_symbol_edge <= w_sym_wrap;
                if (w_car_wrap) begin
                    r_carrier <= ~r_carrier;
                end
                if (w_sym_wrap) begin
                    r_symbol <= ~r_symbol;
                end
            end else begin
                r_div_cnt     <= r_div_cnt + DIV_W'(1);
                r_tick        <= 1'b0;
                r_symbol_edge <= 1'b0;
            end
        end else begin
            // Paused: counters and levels hold so counting resumes without phase loss.
            r_tick        <= 1'b0;
            r_symbol_edge <= 1'b0;
        end
    end

    assign bus.Out_Tick        = r_tick;
    assign bus.Out_Carrier     = r_carrier;
    assign bus.Out_Symbol      = r_symbol;
    assign bus.Out_Symbol_Edge = r_symbol_edge;

endmodule

// File: tb/tb_ir_tick_gen.sv
// tb_ir_tick_gen: self-checking bench for ir_tick_gen.
// A segment table drives enable/restart patterns; each cycle a reference model
// derived from the enabled-edge count pushes the expected outputs to a queue
// that is popped and compared once the DUT has clocked.
`timescale 1ns/1ps
module tb_ir_tick_gen;

    localparam int TICK_DIV = 174;
    localparam int DIV_W    = 11;
    localparam int TPC      = 8;
    localparam int TPS      = 64;
`ifdef IR_TICK_GEN_RUNTIME_DIV_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    typedef struct {
        logic             en;
        logic             rs;
        logic [DIV_W-1:0] dv;
        int               cycles;
        int               ticks;
        int               first;
        int               edges;
        logic             car;
        logic             sym;
    } seg_t;

    logic In_Clock = 1'b0;
    logic In_Reset;

    ir_tick_gen_if #(.DIV_W(DIV_W)) bus ();

    ir_tick_gen #(
        .TICK_DIV         (TICK_DIV),
        .DIV_W            (DIV_W),
        .TICKS_PER_CARRIER(TPC),
        .TICKS_PER_SYMBOL (TPS)
    ) dut (
        .In_Clock(In_Clock),
        .In_Reset(In_Reset),
        .bus     (bus)
    );

    always #5 In_Clock = ~In_Clock;

    int errors = 0;
    int checks = 0;

    // Model state: enabled edges since restart, active divisor, expected {tick, carrier, symbol, edge}.
    int         m_n;
    int         m_d;
    logic [3:0] m_out;
    logic [3:0] sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n   = 0;
        m_d   = TICK_DIV;
        m_out = 4'b0000;
    endtask

    task automatic model_update(input logic en, input logic rs, input logic [DIV_W-1:0] dv);
        int k;
        if (rs) begin
            m_n   = 0;
            m_out = 4'b0000;
            if (RT) m_d = (dv < 2) ? 2 : int'(dv);
        end else if (en) begin
            m_n++;
            if (m_n % m_d == 0) begin
                k     = m_n / m_d;
                m_out = {1'b1, ((k / (TPC / 2)) % 2) == 1, ((k / TPS) % 2) == 1, (k % TPS) == 0};
            end else begin
                m_out[3] = 1'b0;
                m_out[0] = 1'b0;
            end
        end else begin
            m_out[3] = 1'b0;
            m_out[0] = 1'b0;
        end
    endtask

    task automatic drive_cycle(input logic en, input logic rs, input logic [DIV_W-1:0] dv,
                               output logic [3:0] got);
        logic [3:0] exp;
        bus.In_Enable   = en;
        bus.In_Restart  = rs;
        bus.In_Tick_Div = dv;
        model_update(en, rs, dv);
        sb_q.push_back(m_out);
        @(posedge In_Clock);
        #1;
        got = {bus.Out_Tick, bus.Out_Carrier, bus.Out_Symbol, bus.Out_Symbol_Edge};
        exp = sb_q.pop_front();
        check("cycle_outputs{tick,car,sym,edge}", int'(got), int'(exp));
    endtask

    task automatic run_seg(input int idx, input seg_t s);
        logic [3:0] got;
        int ticks;
        int edges;
        int first;
        ticks = 0;
        edges = 0;
        first = 0;
        for (int c = 1; c <= s.cycles; c++) begin
            drive_cycle(s.en, s.rs, s.dv, got);
            if (got[3]) begin
                ticks++;
                if (first == 0) first = c;
            end
            if (got[0]) edges++;
        end
        check($sformatf("seg%0d_ticks", idx), ticks, s.ticks);
        check($sformatf("seg%0d_first_tick", idx), first, s.first);
        check($sformatf("seg%0d_sym_edges", idx), edges, s.edges);
        check($sformatf("seg%0d_carrier_end", idx), int'(got[2]), int'(s.car));
        check($sformatf("seg%0d_symbol_end", idx), int'(got[1]), int'(s.sym));
    endtask

    seg_t tbl[15];

    initial begin
        logic [3:0] got;
        int         waited;
        seg_t       tail;

        tbl[0]  = '{1'b1, 1'b1, 11'd174, 1,     0,  0,   0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 11'd174, 12000, 68, 174, 1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 11'd174, 1,     0,  0,   0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 11'd174, 100,   0,  0,   0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 11'd174, 50,    0,  0,   0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 11'd174, 74,    1,  74,  0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 11'd174, 522,   3,  174, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 11'd174, 90,    0,  0,   0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 11'd174, 1,     0,  0,   0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 11'd174, 174,   1,  174, 0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 11'd174, 20,    0,  0,   0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 11'd10,  1,     0,  0,   0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 11'd10,  180, RT ? 18 : 1, RT ? 10 : 174, 0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 11'd1,   1,     0,  0,   0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 11'd1,   20, RT ? 10 : 0, RT ? 2 : 0, 0, 1'b0, 1'b0};

        bus.In_Enable   = 1'b0;
        bus.In_Restart  = 1'b0;
        bus.In_Tick_Div = 11'd174;
        In_Reset        = 1'b1;
        model_reset();
        repeat (2) @(posedge In_Clock);
        #1;
        check("reset_outputs", int'({bus.Out_Tick, bus.Out_Carrier, bus.Out_Symbol, bus.Out_Symbol_Edge}), 0);
        @(negedge In_Clock);
        In_Reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_seg(i, tbl[i]);
        end

        // Run until a tick is showing, then hit reset asynchronously mid-cycle.
        waited = 0;
        got    = 4'b0000;
        while (!got[3] && waited < 400) begin
            drive_cycle(1'b1, 1'b0, 11'd174, got);
            waited++;
        end
        check("tick_before_async_reset", int'(got[3]), 1);
        #2;
        In_Reset = 1'b1;
        #1;
        check("async_reset_outputs", int'({bus.Out_Tick, bus.Out_Carrier, bus.Out_Symbol, bus.Out_Symbol_Edge}), 0);
        @(negedge In_Clock);
        In_Reset = 1'b0;
        model_reset();

        // After reset the divisor is back to TICK_DIV in every build.
        tail = '{1'b1, 1'b0, 11'd174, 174, 1, 174, 0, 1'b0, 1'b0};
        run_seg(15, tail);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
